// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: pipelined RV32I/RV64I immediate decoder.
//   Decodes the immediate format and value of inst_i combinationally, then
//   carries {imm, fmt, illegal, tag} through PIPE_STAGES register stages
//   with valid/ready handshaking and a synchronous flush.
// Parameters: XLEN (32|64), PIPE_STAGES (1|2), TAG_W (sideband tag width).
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                kill all in-flight entries on the next edge
//   valid_i/ready_o        upstream handshake (ready_o combinational from ready_i)
//   inst_i, tag_i          instruction word and sideband tag
//   valid_o/ready_i        downstream handshake
//   imm_o, fmt_o           decoded immediate and format code
//   illegal_o              malformed shift-immediate encoding
//   tag_o                  tag aligned with imm_o
// Optional feature macro: IMMGEN_CSR_ZIMM_EN (CSR zimm decoding on SYSTEM).
module imm_decode_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned TAG_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      inst_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int unsigned FMT_W = 3;
    localparam int unsigned LAST  = PIPE_STAGES - 1;

    localparam logic [FMT_W-1:0] FMT_NONE  = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I     = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S     = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B     = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U     = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J     = 3'd5;
    localparam logic [FMT_W-1:0] FMT_Z     = 3'd6;
    localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
`ifdef IMMGEN_CSR_ZIMM_EN
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic             sh_ill;
    logic [XLEN-1:0]  dec_imm;
    logic [FMT_W-1:0] dec_fmt;
    logic             dec_ill;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Sign-extended candidates; the signed cast replicates inst[31].
    assign imm_i = XLEN'($signed(inst_i[31:20]));
    assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

    // Shift amount width and the legal upper-bit patterns depend on XLEN.
    always_comb begin
        imm_sh = '0;
        sh_ill = 1'b0;
        if (XLEN == 64) begin
            imm_sh = XLEN'(inst_i[25:20]);
            sh_ill = !((inst_i[31:26] == 6'b000000) ||
                       ((funct3 == 3'b101) && (inst_i[31:26] == 6'b010000)));
        end else begin
            imm_sh = XLEN'(inst_i[24:20]);
            sh_ill = !((inst_i[31:25] == 7'b0000000) ||
                       ((funct3 == 3'b101) && (inst_i[31:25] == 7'b0100000)));
        end
    end

    // Opcode-driven format/immediate select.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            OPC_OP_IMM: begin
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = imm_sh;
                    dec_ill = sh_ill;
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
            end
`ifdef IMMGEN_CSR_ZIMM_EN
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(inst_i[19:15]);
                end
            end
`endif
            default: ;
        endcase
    end

    logic [PIPE_STAGES-1:0] valid_q, valid_d, in_valid, stage_ready;
    logic [XLEN-1:0]        imm_q [PIPE_STAGES];
    logic [XLEN-1:0]        imm_d [PIPE_STAGES];
    logic [XLEN-1:0]        in_imm [PIPE_STAGES];
    logic [FMT_W-1:0]       fmt_q [PIPE_STAGES];
    logic [FMT_W-1:0]       fmt_d [PIPE_STAGES];
    logic [FMT_W-1:0]       in_fmt [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] ill_q, ill_d, in_ill;
    logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d [PIPE_STAGES];
    logic [TAG_W-1:0]       in_tag [PIPE_STAGES];
    logic                   chain_ready;

    // Stage chaining: each stage takes from its predecessor when it is empty
    // or its successor accepts; the ready chain runs back from ready_i.
    always_comb begin
        in_valid    = '0;
        in_ill      = '0;
        in_imm      = '{default: '0};
        in_fmt      = '{default: '0};
        in_tag      = '{default: '0};
        in_valid[0] = valid_i;
        in_imm[0]   = dec_imm;
        in_fmt[0]   = dec_fmt;
        in_ill[0]   = dec_ill;
        in_tag[0]   = tag_i;
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            in_valid[s] = valid_q[s-1];
            in_imm[s]   = imm_q[s-1];
            in_fmt[s]   = fmt_q[s-1];
            in_ill[s]   = ill_q[s-1];
            in_tag[s]   = tag_q[s-1];
        end

        stage_ready = '0;
        chain_ready = ready_i;
        for (int s = int'(PIPE_STAGES) - 1; s >= 0; s--) begin
            stage_ready[s] = ~valid_q[s] | chain_ready;
            chain_ready    = stage_ready[s];
        end

        valid_d = valid_q;
        imm_d   = imm_q;
        fmt_d   = fmt_q;
        ill_d   = ill_q;
        tag_d   = tag_q;
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            if (stage_ready[s]) begin
                valid_d[s] = in_valid[s];
                // Data only loads with a valid entry so held outputs stay stable.
                if (in_valid[s]) begin
                    imm_d[s] = in_imm[s];
                    fmt_d[s] = in_fmt[s];
                    ill_d[s] = in_ill[s];
                    tag_d[s] = in_tag[s];
                end
            end
        end

        // Flush wins over any same-cycle transfer; data registers keep their contents.
        if (flush_i) begin
            valid_d = '0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            ill_q   <= '0;
            imm_q   <= '{default: '0};
            fmt_q   <= '{default: '0};
            tag_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            ill_q   <= ill_d;
            imm_q   <= imm_d;
            fmt_q   <= fmt_d;
            tag_q   <= tag_d;
        end
    end

    assign ready_o   = stage_ready[0];
    assign valid_o   = valid_q[LAST];
    assign imm_o     = imm_q[LAST];
    assign fmt_o     = fmt_q[LAST];
    assign illegal_o = ill_q[LAST];
    assign tag_o     = tag_q[LAST];

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: three instances share the input bus
// (1-stage XLEN=32, 1-stage XLEN=64, 2-stage XLEN=32).
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_i;
    logic [31:0] inst;
    logic [31:0] tag;
    logic        ready_i;

    logic        a_ready, a_valid, a_ill;
    logic [31:0] a_imm, a_tag;
    logic [2:0]  a_fmt;
    logic        b_ready, b_valid, b_ill;
    logic [63:0] b_imm;
    logic [31:0] b_tag;
    logic [2:0]  b_fmt;
    logic        c_ready, c_valid, c_ill;
    logic [31:0] c_imm, c_tag;
    logic [2:0]  c_fmt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(32)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(a_ready),
        .inst_i(inst), .tag_i(tag), .valid_o(a_valid), .ready_i(ready_i), .imm_o(a_imm),
        .fmt_o(a_fmt), .illegal_o(a_ill), .tag_o(a_tag));

    imm_decode_pipe #(.XLEN(64), .PIPE_STAGES(1), .TAG_W(32)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(b_ready),
        .inst_i(inst), .tag_i(tag), .valid_o(b_valid), .ready_i(ready_i), .imm_o(b_imm),
        .fmt_o(b_fmt), .illegal_o(b_ill), .tag_o(b_tag));

    imm_decode_pipe #(.XLEN(32), .PIPE_STAGES(2), .TAG_W(32)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(c_ready),
        .inst_i(inst), .tag_i(tag), .valid_o(c_valid), .ready_i(ready_i), .imm_o(c_imm),
        .fmt_o(c_fmt), .illegal_o(c_ill), .tag_o(c_tag));

    localparam int N = 16;
    logic [31:0] d_inst  [N] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F,
                                 32'h123452B7, 32'h02009093, 32'h40505093, 32'h80002003,
                                 32'hFFF03013, 32'h00001297, 32'h800000B7, 32'h7FF00067,
                                 32'h00000033, 32'h00000073, 32'h00309093, 32'h42505093};
    logic [31:0] d_imm32 [N] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                 32'h12345000, 32'h00000000, 32'h00000005, 32'hFFFFF800,
                                 32'hFFFFFFFF, 32'h00001000, 32'h80000000, 32'h000007FF,
                                 32'h00000000, 32'h00000000, 32'h00000003, 32'h00000005};
    logic [63:0] d_imm64 [N] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                 64'h0000000000000800, 64'h0000000012345000, 64'h0000000000000020,
                                 64'h0000000000000005, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFFFFF,
                                 64'h0000000000001000, 64'hFFFFFFFF80000000, 64'h00000000000007FF,
                                 64'h0, 64'h0, 64'h0000000000000003, 64'h0000000000000025};
    logic [2:0]  d_fmt   [N] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd7, 3'd7, 3'd1,
                                 3'd1, 3'd4, 3'd4, 3'd1, 3'd0, 3'd0, 3'd7, 3'd7};
    logic        d_ill32 [N] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic        d_ill64 [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_imm !== 32'h0 || a_fmt !== 3'd0 || a_ill !== 1'b0 || a_tag !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: valid=%b imm=%h fmt=%0d ill=%b tag=%h, want all 0",
                     a_valid, a_imm, a_fmt, a_ill, a_tag);
        end
        checks++;
        if (b_valid !== 1'b0 || b_imm !== 64'h0 || c_valid !== 1'b0 || c_tag !== 32'h0) begin
            errors++;
            $display("FAIL reset_bc: b_valid=%b b_imm=%h c_valid=%b c_tag=%h, want 0",
                     b_valid, b_imm, c_valid, c_tag);
        end
        checks++;
        if (a_ready !== 1'b1 || c_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: a=%b c=%b, want 1", a_ready, c_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode;
        for (int i = 0; i < N; i++) begin
            valid_i = 1'b1;
            inst    = d_inst[i];
            tag     = 32'h1000 + 32'(i);
            @(posedge clk);
            #1;
            checks++;
            if (a_valid !== 1'b1 || a_tag !== 32'h1000 + 32'(i)) begin
                errors++;
                $display("FAIL dec%0d_valid_tag: valid=%b tag=%h, want 1 %h", i, a_valid, a_tag, 32'h1000 + 32'(i));
            end
            checks++;
            if (a_imm !== d_imm32[i]) begin
                errors++;
                $display("FAIL dec%0d_imm32: got %h want %h", i, a_imm, d_imm32[i]);
            end
            checks++;
            if (a_fmt !== d_fmt[i] || a_ill !== d_ill32[i]) begin
                errors++;
                $display("FAIL dec%0d_fmt_ill32: got %0d/%b want %0d/%b", i, a_fmt, a_ill, d_fmt[i], d_ill32[i]);
            end
            checks++;
            if (b_imm !== d_imm64[i]) begin
                errors++;
                $display("FAIL dec%0d_imm64: got %h want %h", i, b_imm, d_imm64[i]);
            end
            checks++;
            if (b_fmt !== d_fmt[i] || b_ill !== d_ill64[i]) begin
                errors++;
                $display("FAIL dec%0d_fmt_ill64: got %0d/%b want %0d/%b", i, b_fmt, b_ill, d_fmt[i], d_ill64[i]);
            end
        end
        idle(3);
    endtask

    task automatic test_csr_zimm;
        logic [31:0] exp_imm;
        logic [2:0]  exp_fmt;
`ifdef IMMGEN_CSR_ZIMM_EN
        exp_imm = 32'd15;
        exp_fmt = 3'd6;
`else
        exp_imm = 32'd0;
        exp_fmt = 3'd0;
`endif
        valid_i = 1'b1;
        inst    = 32'h0007D073;
        tag     = 32'h77;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_imm !== exp_imm || a_fmt !== exp_fmt) begin
            errors++;
            $display("FAIL csr_zimm: valid=%b imm=%h fmt=%0d want 1 %h %0d", a_valid, a_imm, a_fmt, exp_imm, exp_fmt);
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        int          sent;
        int          recv;
        bit          held;
        logic [31:0] h_imm;
        logic [31:0] h_tag;
        sent    = 0;
        recv    = 0;
        held    = 1'b0;
        h_imm   = '0;
        h_tag   = '0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            valid_i = (sent < 6);
            inst    = d_inst[(sent < 6) ? sent : 0];
            tag     = 32'(sent);
            ready_i = !(cyc >= 4 && cyc <= 6);
            @(negedge clk);
            if (c_valid && ready_i) begin
                checks++;
                if (c_tag !== 32'(recv) || c_imm !== d_imm32[recv]) begin
                    errors++;
                    $display("FAIL b2b_out%0d: tag=%h imm=%h want %h %h", recv, c_tag, c_imm, 32'(recv), d_imm32[recv]);
                end
                recv++;
            end
            if (c_valid && !ready_i) begin
                if (held) begin
                    checks++;
                    if (c_imm !== h_imm || c_tag !== h_tag) begin
                        errors++;
                        $display("FAIL b2b_hold: imm=%h tag=%h want %h %h", c_imm, c_tag, h_imm, h_tag);
                    end
                end
                held  = 1'b1;
                h_imm = c_imm;
                h_tag = c_tag;
            end else begin
                held = 1'b0;
            end
            if (cyc >= 4 && cyc <= 6) begin
                checks++;
                if (c_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_low cyc%0d: got %b want 0", cyc, c_ready);
                end
            end
            if (valid_i && c_ready) sent++;
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        valid_i = 1'b0;
        checks++;
        if (recv !== 6 || sent !== 6) begin
            errors++;
            $display("FAIL b2b_count: sent=%0d recv=%0d want 6 6", sent, recv);
        end
        idle(3);
    endtask

    task automatic test_flush;
        ready_i = 1'b1;
        valid_i = 1'b1;
        inst    = d_inst[0];
        tag     = 32'hA0;
        @(posedge clk);
        #1;
        inst = d_inst[1];
        tag  = 32'hB0;
        @(posedge clk);
        #1;
        checks++;
        if (c_valid !== 1'b1 || c_tag !== 32'hA0) begin
            errors++;
            $display("FAIL flush_prefill: valid=%b tag=%h want 1 a0", c_valid, c_tag);
        end
        inst  = d_inst[2];
        tag   = 32'hC0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        valid_i = 1'b0;
        checks++;
        if (c_valid !== 1'b0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: c_valid=%b a_valid=%b want 0 0", c_valid, a_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (c_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop%0d: valid=%b tag=%h want valid 0", k, c_valid, c_tag);
            end
        end
    endtask

    task automatic test_reset_mid;
        ready_i = 1'b1;
        valid_i = 1'b1;
        inst    = d_inst[4];
        tag     = 32'hD0;
        @(posedge clk);
        #1;
        inst = d_inst[3];
        tag  = 32'hD1;
        checks++;
        if (a_valid !== 1'b1 || a_tag !== 32'hD0) begin
            errors++;
            $display("FAIL rstmid_pre: valid=%b tag=%h want 1 d0", a_valid, a_tag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_imm !== 32'h0 || a_tag !== 32'h0 || c_valid !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: a_valid=%b a_imm=%h a_tag=%h b_valid=%b c_valid=%b want 0",
                     a_valid, a_imm, a_tag, b_valid, c_valid);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_valid !== 1'b0 || c_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_noreplay%0d: a_valid=%b c_valid=%b want 0", k, a_valid, c_valid);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        valid_i = 1'b0;
        inst    = 32'h0;
        tag     = 32'h0;
        ready_i = 1'b1;
        test_reset();
        test_decode();
        test_csr_zimm();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
